mem_bus_monitor: RTL and testbench
==================================

MEM_BUS_MONITOR -- requirements
Module: mem_bus_monitor

Interface
REQ-001 Parameter DATA_W, default 16, width of monitored data bus.
REQ-002 Parameter ADDR_W, default 16, width of monitored address bus.
REQ-003 Parameter FRAME_LEN, default 4 (range 2..16), output frame period in cycles.
REQ-004 Parameter ADDR_SETUP, default 2 (range 1..8), cycles the address must be stable before a write-enable rise.
REQ-005 Parameter CNT_W, default 8, width of event and error counters.
REQ-006 i_clk  in  1  sole clock, rising edge.
REQ-007 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-008 i_memData  in  DATA_W  monitored output data.
REQ-009 i_memAddr  in  ADDR_W  monitored output address.
REQ-010 i_memWrEnable  in  1  monitored write enable.
REQ-011 i_clr  in  1  synchronous clear of counters, flags and FROZEN state.
REQ-012 o_err_valid  out  1  error event reported this cycle.
REQ-013 o_err_code  out  2  bit0 frame error, bit1 address-setup error.
REQ-014 o_frame_cnt  out  CNT_W  count of accepted nonzero data beats, saturating.
REQ-015 o_err_cnt  out  CNT_W  count of errors, saturating.
REQ-016 o_state  out  2  current FSM state.

Function
REQ-017 FSM states: WARMUP, RUN, FROZEN.
REQ-018 WARMUP: history filling; transition to RUN after ADDR_SETUP sampled cycles.
REQ-019 RUN -> FROZEN when o_err_cnt reaches all-ones; FROZEN -> WARMUP only on i_clr.
REQ-020 Zero-run counter: +1 per cycle with i_memData==0, saturating at FRAME_LEN-1; cleared to 0 on nonzero data.
REQ-021 Frame error: i_memData!=0 while the zero-run counter < FRAME_LEN-1; checked in WARMUP and RUN.
REQ-022 Nonzero data without a frame error increments o_frame_cnt (saturating).
REQ-023 Address-setup error: i_memWrEnable rises and i_memAddr differs from the address sampled ADDR_SETUP cycles earlier; checked in RUN only.
REQ-024 Errors are registered: a violation sampled at edge N is reported on o_err_valid/o_err_code after edge N+1 (latency 1).
REQ-025 Simultaneous frame and address errors: o_err_code=2'b11, o_err_cnt += 2, saturating at all-ones.
REQ-026 FROZEN: all checks and counters hold; o_err_valid=0; history keeps sampling.
REQ-027 i_clr has priority over any same-cycle error: counters and zero-run are cleared, the error is dropped, state goes to WARMUP.

Reset
REQ-028 Asynchronous assertion of i_rst_n=0: state=WARMUP, zero-run=FRAME_LEN-1 (reset treated as idle history), address history=0, previous write enable=0, all outputs 0.
REQ-029 Reset asserted mid-operation discards pending errors; release is synchronous to i_clk.

Configuration
REQ-030 Macro MEM_MON_STICKY_EN defined: o_err_code bits are sticky (OR-accumulated) until i_clr or reset; o_err_valid still pulses one cycle per event.
REQ-031 Macro MEM_MON_STICKY_EN undefined: o_err_code equals the current cycle's error bits, 0 otherwise.

Structure
REQ-032 Package mem_mon_pkg holds the state enum, the error-code typedef and bit indices, and default parameter constants.
REQ-033 Sub-module mem_mon_delay_line: parametrised ADDR_W x ADDR_SETUP shift register giving the delayed address.

Verification (FRAME_LEN=4, ADDR_SETUP=2, CNT_W=8)
REQ-034 Data 0,0,0,0x12 after reset -> no error; o_frame_cnt=1 one cycle later.
REQ-035 Data 0x12,0,0x34 -> o_err_valid=1 with o_err_code=2'b01 one cycle after 0x34; o_err_cnt=1.
REQ-036 Address 0x40 held for 2 cycles, then i_memWrEnable rises -> no error; address 0x40->0x44 one cycle before the rise -> o_err_code=2'b10.
REQ-037 Frame and address violations in the same cycle -> o_err_code=2'b11, o_err_cnt +2; 255 errors -> o_state=FROZEN, counters hold; i_clr -> WARMUP with counters 0.
REQ-038 Reset asserted between a violation and its report -> no o_err_valid pulse; all outputs 0.
REQ-039 Two errors then 10 clean cycles: with MEM_MON_STICKY_EN, o_err_code stays 2'b01; without it, o_err_code=0.

Source files
------------

// File: rtl/mem_mon_pkg.sv
// rtl/mem_mon_pkg.sv - shared types and defaults for the memory bus monitor
package mem_mon_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_FRAME_LEN  = 4;
  localparam int DEF_ADDR_SETUP = 2;
  localparam int DEF_CNT_W      = 8;

  localparam int ERR_FRAME_BIT = 0;
  localparam int ERR_ADDR_BIT  = 1;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } mon_state_e;

  typedef logic [1:0] err_code_t;

  // Number of error events carried by one code (0, 1 or 2).
  function automatic logic [1:0] err_weight(input err_code_t code);
    return {1'b0, code[ERR_FRAME_BIT]} + {1'b0, code[ERR_ADDR_BIT]};
  endfunction

endpackage

// File: rtl/mem_mon_delay_line.sv
// rtl/mem_mon_delay_line.sv - W x DEPTH shift register giving the address sampled DEPTH cycles ago
module mem_mon_delay_line #(
  parameter int W     = 16,
  parameter int DEPTH = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_sr [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_sr[k] <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int k = 1; k < DEPTH; k++) r_sr[k] <= r_sr[k-1];
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/mem_bus_monitor.sv
// rtl/mem_bus_monitor.sv - frame and address-setup checker for a memory bus; MEM_MON_STICKY_EN makes o_err_code sticky
module mem_bus_monitor
  import mem_mon_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FRAME_LEN  = DEF_FRAME_LEN,
  parameter int ADDR_SETUP = DEF_ADDR_SETUP,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_memData,
  input  logic [ADDR_W-1:0] i_memAddr,
  input  logic              i_memWrEnable,
  input  logic              i_clr,
  output logic              o_err_valid,
  output logic [1:0]        o_err_code,
  output logic [CNT_W-1:0]  o_frame_cnt,
  output logic [CNT_W-1:0]  o_err_cnt,
  output logic [1:0]        o_state
);

  localparam int               ZW   = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [ZW-1:0]    ZMAX = ZW'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  mon_state_e       r_state;
  logic [ZW-1:0]    r_zrun;
  logic [3:0]       r_warm;
  logic             r_we_prev;
  logic             r_err_valid;
  err_code_t        r_err_code;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic [ADDR_W-1:0] w_addr_dly;
  logic              w_active;
  logic              w_nonzero;
  err_code_t         w_err;
  logic [CNT_W:0]    w_err_sum;
  logic [CNT_W-1:0]  w_err_cnt_nxt;
  logic [CNT_W-1:0]  w_frame_cnt_nxt;
  logic [ZW-1:0]     w_zrun_nxt;

  mem_mon_delay_line #(
    .W     (ADDR_W),
    .DEPTH (ADDR_SETUP)
  ) u_addr_hist (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_memAddr),
    .o_q     (w_addr_dly)
  );

  always_comb begin
    w_active  = (r_state != ST_FROZEN);
    w_nonzero = |i_memData;
    w_err     = '0;
    w_err[ERR_FRAME_BIT] = w_active && w_nonzero && (r_zrun < ZMAX);
    w_err[ERR_ADDR_BIT]  = (r_state == ST_RUN) && i_memWrEnable && !r_we_prev &&
                           (i_memAddr != w_addr_dly);
    w_err_sum       = {1'b0, r_err_cnt} + (CNT_W+1)'(err_weight(w_err));
    w_err_cnt_nxt   = w_err_sum[CNT_W] ? CMAX : w_err_sum[CNT_W-1:0];
    w_frame_cnt_nxt = (r_frame_cnt == CMAX) ? CMAX : r_frame_cnt + CNT_W'(1);
    if (w_nonzero)
      w_zrun_nxt = '0;
    else
      w_zrun_nxt = (r_zrun == ZMAX) ? ZMAX : r_zrun + ZW'(1);
  end

  // Write-enable history keeps sampling through clear and FROZEN.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_we_prev <= 1'b0;
    else          r_we_prev <= i_memWrEnable;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_WARMUP;
      r_zrun      <= ZMAX;
      r_warm      <= '0;
      r_err_valid <= 1'b0;
      r_err_code  <= '0;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else if (i_clr) begin
      r_state     <= ST_WARMUP;
      r_zrun      <= '0;
      r_warm      <= '0;
      r_err_valid <= 1'b0;
      r_err_code  <= '0;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_err_valid <= |w_err;
`ifdef MEM_MON_STICKY_EN
      r_err_code  <= r_err_code | w_err;
`else
      r_err_code  <= w_err;
`endif
      if (w_active) begin
        r_zrun    <= w_zrun_nxt;
        r_err_cnt <= w_err_cnt_nxt;
        if (w_nonzero && !w_err[ERR_FRAME_BIT]) r_frame_cnt <= w_frame_cnt_nxt;
      end
      case (r_state)
        ST_WARMUP: begin
          if (r_warm == 4'(ADDR_SETUP - 1)) begin
            r_state <= ST_RUN;
            r_warm  <= '0;
          end else begin
            r_warm <= r_warm + 4'd1;
          end
        end
        ST_RUN:    if (w_err_cnt_nxt == CMAX) r_state <= ST_FROZEN;
        default:   r_state <= r_state;
      endcase
    end
  end

  assign o_err_valid = r_err_valid;
  assign o_err_code  = r_err_code;
  assign o_frame_cnt = r_frame_cnt;
  assign o_err_cnt   = r_err_cnt;
  assign o_state     = r_state;

endmodule

// File: tb/tb_mem_bus_monitor.sv
// tb/tb_mem_bus_monitor.sv - scoreboard bench for mem_bus_monitor against a cycle-level reference model
module tb_mem_bus_monitor;

  localparam int FL = 4;
  localparam int AS = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] d = '0;
  logic [15:0] a = '0;
  logic        we = 1'b0;
  logic        clr = 1'b0;
  logic        o_err_valid;
  logic [1:0]  o_err_code;
  logic [7:0]  o_frame_cnt;
  logic [7:0]  o_err_cnt;
  logic [1:0]  o_state;

  mem_bus_monitor #(
    .DATA_W(16), .ADDR_W(16), .FRAME_LEN(FL), .ADDR_SETUP(AS), .CNT_W(8)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_memData(d), .i_memAddr(a),
    .i_memWrEnable(we), .i_clr(clr), .o_err_valid(o_err_valid),
    .o_err_code(o_err_code), .o_frame_cnt(o_frame_cnt), .o_err_cnt(o_err_cnt),
    .o_state(o_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         tag;
    logic       v;
    logic [1:0] code;
    logic [7:0] fc;
    logic [7:0] ec;
    logic [1:0] st;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode 0 warmup, 1 run, 2 frozen; m_zeros counts zero beats since the last nonzero one.
  int          m_mode, m_warm, m_zeros, m_fc, m_ec;
  logic        m_v, m_weprev;
  logic [1:0]  m_code;
  logic [15:0] m_hist[$];

  task automatic model_reset();
    m_mode = 0; m_warm = 0; m_zeros = FL - 1; m_fc = 0; m_ec = 0;
    m_v = 1'b0; m_weprev = 1'b0; m_code = 2'b00;
    m_hist.delete();
    repeat (AS) m_hist.push_back(16'h0);
  endtask

  task automatic model_step(input logic [15:0] dd, input logic [15:0] aa, input logic w, input logic c);
    logic ferr, aerr, active;
    active = (m_mode != 2);
    ferr = active && (dd != 0) && (m_zeros < FL - 1);
    aerr = (m_mode == 1) && w && !m_weprev && (aa != m_hist[0]);
    if (c) begin
      m_mode = 0; m_warm = 0; m_zeros = 0; m_fc = 0; m_ec = 0; m_v = 1'b0; m_code = 2'b00;
    end else begin
      m_v = ferr || aerr;
`ifdef MEM_MON_STICKY_EN
      m_code = m_code | {aerr, ferr};
`else
      m_code = {aerr, ferr};
`endif
      if (active) begin
        if (dd != 0 && !ferr) m_fc = (m_fc < 255) ? m_fc + 1 : 255;
        m_ec = m_ec + int'(ferr) + int'(aerr);
        if (m_ec > 255) m_ec = 255;
        m_zeros = (dd != 0) ? 0 : m_zeros + 1;
      end
      if (m_mode == 0) begin
        m_warm++;
        if (m_warm == AS) begin m_mode = 1; m_warm = 0; end
      end else if (m_mode == 1 && m_ec == 255) begin
        m_mode = 2;
      end
    end
    m_hist.push_back(aa);
    void'(m_hist.pop_front());
    m_weprev = w;
  endtask

  // Called just after a rising edge; drives one cycle and queues the expected post-edge outputs.
  task automatic step(input logic [15:0] dd, input logic [15:0] aa, input logic w, input logic c);
    exp_t e;
    d = dd; a = aa; we = w; clr = c;
    model_step(dd, aa, w, c);
    e.tag = cyc + 1; e.v = m_v; e.code = m_code;
    e.fc = 8'(m_fc); e.ec = 8'(m_ec); e.st = 2'(m_mode);
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if ({o_err_valid, o_err_code, o_frame_cnt, o_err_cnt, o_state} != 21'd0) begin
      n_bad++;
      $display("FAIL %s: got v=%0b code=%0b fc=%0d ec=%0d st=%0d, need all zero",
               name, o_err_valid, o_err_code, o_frame_cnt, o_err_cnt, o_state);
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk); #1;
    rst_n = 1'b0;
    q.delete();
    model_reset();
    #1 check_zero({name, "_assert"});
    d = '0; a = '0; we = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_zero({name, "_held"});
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].tag <= cyc) begin
      e = q.pop_front();
      n_cmp++;
      if (o_err_valid !== e.v || o_err_code !== e.code || o_frame_cnt !== e.fc ||
          o_err_cnt !== e.ec || o_state !== e.st) begin
        n_bad++;
        $display("FAIL cycle%0d: got v=%0b code=%0b fc=%0d ec=%0d st=%0d, need v=%0b code=%0b fc=%0d ec=%0d st=%0d",
                 e.tag, o_err_valid, o_err_code, o_frame_cnt, o_err_cnt, o_state,
                 e.v, e.code, e.fc, e.ec, e.st);
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    model_reset();
    #2 check_zero("por_assert");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Zero run then nonzero: clean beat.
    step(16'h0, 16'h0, 0, 0); step(16'h0, 16'h0, 0, 0); step(16'h0, 16'h0, 0, 0);
    step(16'h12, 16'h0, 0, 0);
    // Nonzero too soon after previous nonzero: frame error.
    step(16'h12, 16'h0, 0, 0); step(16'h0, 16'h0, 0, 0); step(16'h34, 16'h0, 0, 0);
    // Stable address before write-enable rise, then late address change.
    step(16'h0, 16'h40, 0, 0); step(16'h0, 16'h40, 0, 0); step(16'h0, 16'h40, 0, 0);
    step(16'h0, 16'h40, 1, 0); step(16'h0, 16'h40, 0, 0); step(16'h0, 16'h40, 0, 0);
    step(16'h0, 16'h44, 0, 0); step(16'h0, 16'h44, 1, 0); step(16'h0, 16'h44, 0, 0);
    // Both violations in one cycle.
    step(16'h0, 16'h40, 0, 0); step(16'h0, 16'h40, 0, 0); step(16'h0, 16'h40, 0, 0);
    step(16'h1, 16'h40, 0, 0); step(16'h1, 16'h44, 1, 0); step(16'h0, 16'h44, 0, 0);

    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0,
           ($urandom_range(0, 1) == 0) ? 16'h40 : 16'h44,
           $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);

    // Drive error count to saturation, hold in FROZEN, then clear.
    step(16'h0, 16'h40, 0, 1);
    for (int i = 0; i < 300; i++)
      step(16'(i + 1), (i % 3 == 0) ? 16'h44 : 16'h40, (i % 3 == 0), 0);
    for (int i = 0; i < 5; i++) step(16'h5, 16'h48, (i % 2 == 0), 0);
    step(16'h0, 16'h0, 0, 1);
    step(16'h0, 16'h0, 0, 0); step(16'h0, 16'h0, 0, 0);

    // Clear beats a same-cycle error.
    step(16'h9, 16'h0, 0, 0); step(16'h9, 16'h0, 0, 1); step(16'h0, 16'h0, 0, 0);

    // Reset between a violation and its report.
    step(16'h0, 16'h0, 0, 0); step(16'h0, 16'h0, 0, 0); step(16'h0, 16'h0, 0, 0);
    step(16'h3, 16'h0, 0, 0);
    d = 16'h7;
    do_reset("mid_reset");

    // Two errors then clean cycles: sticky vs live error code.
    step(16'h0, 16'h0, 0, 1);
    step(16'h5, 16'h0, 0, 0); step(16'h5, 16'h0, 0, 0);
    for (int i = 0; i < 10; i++) step(16'h0, 16'h0, 0, 0);

    step(16'h0, 16'h0, 0, 0);
    @(negedge clk); #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, need 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
